// File: rtl/fire_control_pkg.sv
// Shared definitions for the fire control path: FSM state encoding and counter sizing.
package fire_control_pkg;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_FIRE         = 2'd1,
    S_COOLDOWN     = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_e;

  // Bits needed to hold values 0..n-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter debounce; Level follows In_Raw only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement.
module button_debounce
  import fire_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic In_Raw,
  output logic Level
);

  localparam int unsigned DB_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  // Synchroniser and debounce next-state.
  always_comb begin
    s1_d     = In_Raw;
    s2_d     = s1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    if (s2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign Level = level_q;

endmodule

// File: rtl/fire_control.sv
// Trigger-to-fire-request stage for the Bullet block: debounce, edge detect,
// fire gating, post-shot cooldown and a saturating shot counter.
// Optional macro FIRE_CONTROL_AUTO_FIRE_EN: a held trigger repeats after each
// cooldown instead of requiring a release between shots.
module fire_control
  import fire_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned COOLDOWN_CYCLES = 2500000,
  parameter int unsigned SHOT_CNT_W      = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Button_Raw,
  input  logic                  Game_Active,
  input  logic                  Bullet_Onscreen,
  output logic                  Bullet_Fired,
  output logic                  Fire_Blocked,
  output logic [SHOT_CNT_W-1:0] Shots_Fired,
  output logic                  Button_Level
);

  localparam int unsigned CD_W = clog2(COOLDOWN_CYCLES);
  localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [SHOT_CNT_W-1:0] SHOTS_MAX = {SHOT_CNT_W{1'b1}};

  state_e                  state_q, state_d;
  logic [CD_W-1:0]         cd_cnt_q, cd_cnt_d;
  logic [SHOT_CNT_W-1:0]   shots_q, shots_d;
  logic                    fire_blocked_q, fire_blocked_d;
  logic                    lvl_dly_q, lvl_dly_d;
  logic                    button_level;
  logic                    press;
  logic                    can_fire;
  logic                    cd_done;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clk   (Clk),
    .Reset (Reset),
    .In_Raw(Button_Raw),
    .Level (button_level)
  );

  assign press    = button_level & ~lvl_dly_q;
  assign can_fire = Game_Active & ~Bullet_Onscreen;
  assign cd_done  = (cd_cnt_q == CD_LAST);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; losing Game_Active aborts everything except an issued shot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
`ifdef FIRE_CONTROL_AUTO_FIRE_EN
        if (button_level && can_fire) state_d = S_FIRE;
`else
        if (press && can_fire) state_d = S_FIRE;
`endif
      end
      S_FIRE: state_d = S_COOLDOWN;
      S_COOLDOWN: begin
        if (cd_done) begin
`ifdef FIRE_CONTROL_AUTO_FIRE_EN
          state_d = (button_level && can_fire) ? S_FIRE : S_IDLE;
`else
          state_d = button_level ? S_WAIT_RELEASE : S_IDLE;
`endif
        end
      end
      S_WAIT_RELEASE: begin
`ifdef FIRE_CONTROL_AUTO_FIRE_EN
        state_d = S_IDLE;
`else
        if (!button_level) state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (!Game_Active && (state_q != S_FIRE)) state_d = S_IDLE;
  end

  // Counter, shot tally, block flag and edge-detect next values.
  always_comb begin
    cd_cnt_d       = '0;
    shots_d        = shots_q;
    lvl_dly_d      = button_level;
    fire_blocked_d = (state_d != S_IDLE) | Bullet_Onscreen | ~Game_Active;
    if (state_q == S_COOLDOWN && Game_Active && !cd_done) begin
      cd_cnt_d = cd_cnt_q + CD_W'(1);
    end
    if (state_q == S_FIRE && shots_q != SHOTS_MAX) begin
      shots_d = shots_q + SHOT_CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cd_cnt_q       <= '0;
      shots_q        <= '0;
      fire_blocked_q <= 1'b1;
      lvl_dly_q      <= 1'b0;
    end else begin
      cd_cnt_q       <= cd_cnt_d;
      shots_q        <= shots_d;
      fire_blocked_q <= fire_blocked_d;
      lvl_dly_q      <= lvl_dly_d;
    end
  end

  assign Bullet_Fired = (state_q == S_FIRE);
  assign Fire_Blocked = fire_blocked_q;
  assign Shots_Fired  = shots_q;
  assign Button_Level = button_level;

endmodule

// File: tb/tb_fire_control.sv
// Directed bench for fire_control with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, SHOT_CNT_W=4.
module tb_fire_control;

  logic       Clk;
  logic       Reset;
  logic       Button_Raw;
  logic       Game_Active;
  logic       Bullet_Onscreen;
  logic       Bullet_Fired;
  logic       Fire_Blocked;
  logic [3:0] Shots_Fired;
  logic       Button_Level;

  fire_control #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(8),
    .SHOT_CNT_W     (4)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Button_Raw     (Button_Raw),
    .Game_Active    (Game_Active),
    .Bullet_Onscreen(Bullet_Onscreen),
    .Bullet_Fired   (Bullet_Fired),
    .Fire_Blocked   (Fire_Blocked),
    .Shots_Fired    (Shots_Fired),
    .Button_Level   (Button_Level)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic raw;
    logic fired;
    logic blocked;
    logic level;
    int   shots;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   pulses = 0;
  int   last_pulse = -100;
  int   prev_pulse = -100;
  int   consec = 0;
  logic prev_fired = 1'b0;
  int   exp_shots = 0;
  int   p0;
  int   start;

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input logic raw, input logic f, input logic b, input logic l, input int s);
    vec_t v;
    v.raw = raw; v.fired = f; v.blocked = b; v.level = l; v.shots = s;
    tbl.push_back(v);
  endtask

  // One clock: apply inputs, step past the edge, observe the fire pulse.
  task automatic drive(input logic raw, input logic ga, input logic bo, input logic rst);
    Button_Raw = raw; Game_Active = ga; Bullet_Onscreen = bo; Reset = rst;
    @(posedge Clk);
    #1;
    cyc = cyc + 1;
    if (Bullet_Fired) begin
      if (prev_fired) consec = consec + 1;
      pulses     = pulses + 1;
      prev_pulse = last_pulse;
      last_pulse = cyc;
    end
    prev_fired = Bullet_Fired;
  endtask

  task automatic run(input int n, input logic raw, input logic ga, input logic bo);
    for (int k = 0; k < n; k++) drive(raw, ga, bo, 1'b0);
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 15) ? 15 : a + b;
  endfunction

  initial begin
    // Clean press: level at +5, pulse at +6, count and block from +7/+6
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0);
    add(1, 1, 1, 1, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 1, 1, 1);
`ifndef FIRE_CONTROL_AUTO_FIRE_EN
    for (int i = 0; i < 2; i++) add(1, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 1);
    add(0, 0, 1, 0, 1);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 1);
`endif

    Button_Raw = 1'b0; Game_Active = 1'b1; Bullet_Onscreen = 1'b0; Reset = 1'b1;

    // Reset values
    drive(0, 1, 0, 1);
    check("rst_fired",   32'(Bullet_Fired), 0);
    check("rst_blocked", 32'(Fire_Blocked), 1);
    check("rst_shots",   32'(Shots_Fired),  0);
    check("rst_level",   32'(Button_Level), 0);
    drive(0, 1, 0, 0);
    check("idle_blocked", 32'(Fire_Blocked), 0);

    // Table-driven clean press
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].raw, 1, 0, 0);
      check($sformatf("tbl%0d_fired", i),   32'(Bullet_Fired), 32'(tbl[i].fired));
      check($sformatf("tbl%0d_blocked", i), 32'(Fire_Blocked), 32'(tbl[i].blocked));
      check($sformatf("tbl%0d_level", i),   32'(Button_Level), 32'(tbl[i].level));
      check($sformatf("tbl%0d_shots", i),   32'(Shots_Fired),  tbl[i].shots);
    end
    exp_shots = 1;

`ifdef FIRE_CONTROL_AUTO_FIRE_EN
    // Held trigger repeats every 9 cycles
    p0 = pulses;
    run(12, 1, 1, 0);
    check("auto_hold_pulses", pulses - p0, 2);
    check("auto_hold_period", last_pulse - prev_pulse, 9);
    run(30, 0, 1, 0);
    exp_shots = 3;
    check("auto_hold_shots", 32'(Shots_Fired), exp_shots);
`endif

    // Bounce: 3 high, 2 low, then stable high for 8 cycles
    p0 = pulses;
    run(3, 1, 1, 0);
    run(2, 0, 1, 0);
    start = cyc + 1;
    run(8, 1, 1, 0);
    run(12, 0, 1, 0);
    check("bounce_pulses", pulses - p0, 1);
    check("bounce_delay", last_pulse - start, 6);
    exp_shots = sat_add(exp_shots, 1);
    check("bounce_shots", 32'(Shots_Fired), exp_shots);

    // Gating: bullet onscreen, then game inactive
    p0 = pulses;
    run(12, 1, 1, 1);
    check("gate_bo_blocked", 32'(Fire_Blocked), 1);
    run(12, 0, 1, 1);
    run(12, 1, 0, 0);
    check("gate_ga_blocked", 32'(Fire_Blocked), 1);
    run(12, 0, 0, 0);
    run(4, 0, 1, 0);
    check("gate_pulses", pulses - p0, 0);
    check("gate_shots", 32'(Shots_Fired), exp_shots);
    check("gate_unblocked", 32'(Fire_Blocked), 0);

`ifndef FIRE_CONTROL_AUTO_FIRE_EN
    // Semi-auto: long hold fires once, release and re-press fires again
    p0 = pulses;
    run(40, 1, 1, 0);
    check("hold_pulses", pulses - p0, 1);
    check("hold_blocked", 32'(Fire_Blocked), 1);
    run(12, 0, 1, 0);
    run(20, 1, 1, 0);
    run(14, 0, 1, 0);
    check("repress_pulses", pulses - p0, 2);
    exp_shots = sat_add(exp_shots, 2);
    check("repress_shots", 32'(Shots_Fired), exp_shots);
`endif

    // Saturation: 20 clean presses
    p0 = pulses;
    for (int n = 0; n < 20; n++) begin
      run(8, 1, 1, 0);
      run(22, 0, 1, 0);
    end
    check("sat_pulses", pulses - p0, 20);
    check("sat_shots", 32'(Shots_Fired), 15);

    // Reset three cycles after a pulse, trigger still held
    p0 = pulses;
    run(9, 1, 1, 0);
    check("rstcd_pulse", pulses - p0, 1);
    drive(1, 1, 0, 1);
    check("rstcd_fired",   32'(Bullet_Fired), 0);
    check("rstcd_blocked", 32'(Fire_Blocked), 1);
    check("rstcd_shots",   32'(Shots_Fired),  0);
    check("rstcd_level",   32'(Button_Level), 0);
    p0 = pulses;
    start = cyc + 1;
    run(20, 1, 1, 0);
`ifdef FIRE_CONTROL_AUTO_FIRE_EN
    check("post_rst_pulses", pulses - p0, 2);
    check("post_rst_period", last_pulse - prev_pulse, 9);
    check("post_rst_shots", 32'(Shots_Fired), 2);
`else
    check("post_rst_pulses", pulses - p0, 1);
    check("post_rst_delay", last_pulse - start, 6);
    check("post_rst_shots", 32'(Shots_Fired), 1);
`endif

    check("no_double_pulse", consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
